// File: rtl/soc_or1k_wb_jtag_mem.sv
// Dual-memory JTAG debug core: two identical TAPs, each with its own word memory,
// sharing TMS/TCK/TDI and driving separate TDO pads. JTAG pins are oversampled on wb_clk_i.
module soc_or1k_wb_jtag_mem #(
  parameter int unsigned MEM_SIZE = 32'h02000000,
  parameter logic [31:0] IDCODE0  = 32'h149511C3,
  parameter logic [31:0] IDCODE1  = 32'h249511C3
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic tms_pad_i,
  input  logic tck_pad_i,
  input  logic tdi_pad_i,
  output logic tdo_pad0_o,
  output logic tdo_pad1_o
);

  localparam int unsigned AddrW = $clog2(MEM_SIZE);
  localparam int unsigned IdxW  = AddrW - 2;
  localparam int unsigned Words = MEM_SIZE / 4;

  localparam logic [3:0] IrIdcode = 4'b0010;
  localparam logic [3:0] IrDebug  = 4'b1000;

  typedef enum logic [3:0] {
    StTlr, StIdle,
    StSelDr, StCapDr, StShDr, StEx1Dr, StPauseDr, StEx2Dr, StUpdDr,
    StSelIr, StCapIr, StShIr, StEx1Ir, StPauseIr, StEx2Ir, StUpdIr
  } tap_state_e;

  // Internal reset: asserts with wb_rst_i, releases on the 2nd clock after it falls.
  logic rst_meta_q;
  logic wb_rst;

  // Reset synchronizer.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rst_meta_q <= 1'b1;
      wb_rst     <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      wb_rst     <= rst_meta_q;
    end
  end

  // Pin oversampling: TCK gets a third stage for edge detection, TMS/TDI are taken
  // from stage 2 so they line up with the detected edge.
  logic [2:0] tck_sync_q;
  logic [1:0] tms_sync_q;
  logic [1:0] tdi_sync_q;
  logic       tck_rise;
  logic       tck_fall;
  logic       tms;
  logic       tdi;

  // JTAG pin synchronizers.
  always_ff @(posedge wb_clk_i or posedge wb_rst) begin
    if (wb_rst) begin
      tck_sync_q <= '0;
      tms_sync_q <= '0;
      tdi_sync_q <= '0;
    end else begin
      tck_sync_q <= {tck_sync_q[1:0], tck_pad_i};
      tms_sync_q <= {tms_sync_q[0], tms_pad_i};
      tdi_sync_q <= {tdi_sync_q[0], tdi_pad_i};
    end
  end

  assign tck_rise = tck_sync_q[1] & ~tck_sync_q[2];
  assign tck_fall = ~tck_sync_q[1] & tck_sync_q[2];
  assign tms      = tms_sync_q[1];
  assign tdi      = tdi_sync_q[1];

  // Per-TAP memory request/response wiring.
  logic            tdo       [2];
  logic            mem_we    [2];
  logic [IdxW-1:0] mem_idx   [2];
  logic [31:0]     mem_wdata [2];
  logic [31:0]     mem_rdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_tap
    localparam logic [31:0] IdCode = (g == 0) ? IDCODE0 : IDCODE1;

    tap_state_e  state_q, state_d;
    logic [3:0]  ir_q;
    logic [3:0]  ir_sr_q;
    logic        bypass_q;
    logic [31:0] idcode_sr_q;
    logic [64:0] dbg_sr_q;
    logic [31:0] last_addr_q;
    logic [31:0] rdata_q;
    logic        tdo_q;
    logic        sel_idcode;
    logic        sel_debug;
    logic        upd_dr;
    logic        upd_ir;
    logic        dr_bit0;

    // TAP state register.
    always_ff @(posedge wb_clk_i or posedge wb_rst) begin
      if (wb_rst) state_q <= StTlr;
      else        state_q <= state_d;
    end

    // IEEE 1149.1 next-state logic, advanced only on a detected TCK rising edge.
    always_comb begin
      state_d = state_q;
      if (tck_rise) begin
        case (state_q)
          StTlr:     state_d = tms ? StTlr     : StIdle;
          StIdle:    state_d = tms ? StSelDr   : StIdle;
          StSelDr:   state_d = tms ? StSelIr   : StCapDr;
          StCapDr:   state_d = tms ? StEx1Dr   : StShDr;
          StShDr:    state_d = tms ? StEx1Dr   : StShDr;
          StEx1Dr:   state_d = tms ? StUpdDr   : StPauseDr;
          StPauseDr: state_d = tms ? StEx2Dr   : StPauseDr;
          StEx2Dr:   state_d = tms ? StUpdDr   : StShDr;
          StUpdDr:   state_d = tms ? StSelDr   : StIdle;
          StSelIr:   state_d = tms ? StTlr     : StCapIr;
          StCapIr:   state_d = tms ? StEx1Ir   : StShIr;
          StShIr:    state_d = tms ? StEx1Ir   : StShIr;
          StEx1Ir:   state_d = tms ? StUpdIr   : StPauseIr;
          StPauseIr: state_d = tms ? StEx2Ir   : StPauseIr;
          StEx2Ir:   state_d = tms ? StUpdIr   : StShIr;
          StUpdIr:   state_d = tms ? StSelDr   : StIdle;
          default:   state_d = StTlr;
        endcase
      end
    end

    // Update states are never re-entered from themselves, so entry is a one-cycle pulse.
    assign upd_dr     = tck_rise & (state_d == StUpdDr);
    assign upd_ir     = tck_rise & (state_d == StUpdIr);
    // Unknown instruction codes fall back to BYPASS.
    assign sel_idcode = (ir_q == IrIdcode);
    assign sel_debug  = (ir_q == IrDebug);
    assign dr_bit0    = sel_debug ? dbg_sr_q[0] : (sel_idcode ? idcode_sr_q[0] : bypass_q);

    assign mem_we[g]    = upd_dr & sel_debug & dbg_sr_q[64];
    assign mem_idx[g]   = dbg_sr_q[34 +: IdxW];
    assign mem_wdata[g] = dbg_sr_q[31:0];
    assign tdo[g]       = tdo_q;

    // Instruction register: capture, shift and update.
    always_ff @(posedge wb_clk_i or posedge wb_rst) begin
      if (wb_rst) begin
        ir_q    <= IrIdcode;
        ir_sr_q <= '0;
      end else begin
        if (state_q == StTlr) ir_q <= IrIdcode;
        else if (upd_ir)      ir_q <= ir_sr_q;
        if (tck_rise && state_q == StCapIr) ir_sr_q <= 4'b0101;
        if (tck_rise && state_q == StShIr)  ir_sr_q <= {tdi, ir_sr_q[3:1]};
      end
    end

    // Data registers: only the one selected by IR captures or shifts.
    always_ff @(posedge wb_clk_i or posedge wb_rst) begin
      if (wb_rst) begin
        bypass_q    <= 1'b0;
        idcode_sr_q <= '0;
        dbg_sr_q    <= '0;
      end else if (tck_rise && state_q == StCapDr) begin
        if (sel_debug)       dbg_sr_q    <= {1'b0, last_addr_q, rdata_q};
        else if (sel_idcode) idcode_sr_q <= IdCode;
        else                 bypass_q    <= 1'b0;
      end else if (tck_rise && state_q == StShDr) begin
        if (sel_debug)       dbg_sr_q    <= {tdi, dbg_sr_q[64:1]};
        else if (sel_idcode) idcode_sr_q <= {tdi, idcode_sr_q[31:1]};
        else                 bypass_q    <= tdi;
      end
    end

    // Debug access bookkeeping; the memory write itself happens in the memory block.
    always_ff @(posedge wb_clk_i or posedge wb_rst) begin
      if (wb_rst) begin
        last_addr_q <= '0;
        rdata_q     <= '0;
      end else if (upd_dr && sel_debug) begin
        last_addr_q <= dbg_sr_q[63:32];
        if (!dbg_sr_q[64]) rdata_q <= mem_rdata[g];
      end
    end

    // TDO register, updated on the TCK falling edge while shifting.
    always_ff @(posedge wb_clk_i or posedge wb_rst) begin
      if (wb_rst) begin
        tdo_q <= 1'b0;
      end else if (tck_fall) begin
        if (state_q == StShIr)      tdo_q <= ir_sr_q[0];
        else if (state_q == StShDr) tdo_q <= dr_bit0;
      end
    end
  end

  assign tdo_pad0_o = tdo[0];
  assign tdo_pad1_o = tdo[1];

  // Memory 0: not reset, contents survive wb_rst.
  if (1) begin : wb_bfm_memory0
    if (1) begin : ram0
      logic [31:0] mem [Words];

      // Word write from TAP 0.
      always_ff @(posedge wb_clk_i) begin
        if (mem_we[0]) mem[mem_idx[0]] <= mem_wdata[0];
      end

      assign mem_rdata[0] = mem[mem_idx[0]];
    end
  end

  // Memory 1: not reset, contents survive wb_rst.
  if (1) begin : wb_bfm_memory1
    if (1) begin : ram0
      logic [31:0] mem [Words];

      // Word write from TAP 1.
      always_ff @(posedge wb_clk_i) begin
        if (mem_we[1]) mem[mem_idx[1]] <= mem_wdata[1];
      end

      assign mem_rdata[1] = mem[mem_idx[1]];
    end
  end

endmodule

// File: tb/tb_soc_or1k_wb_jtag_mem.sv
// Bench for soc_or1k_wb_jtag_mem: drives JTAG sequences and compares TDO streams and
// memory contents against a word-level model of the two debug memories.
module tb_soc_or1k_wb_jtag_mem;

  localparam int unsigned MEM_SIZE = 32'h02000000;
  localparam logic [31:0] IDCODE0  = 32'h149511C3;
  localparam logic [31:0] IDCODE1  = 32'h249511C3;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i;
  logic tms_pad_i;
  logic tck_pad_i;
  logic tdi_pad_i;
  logic tdo_pad0_o;
  logic tdo_pad1_o;

  int tests = 0;
  int fails = 0;

  // Reference model: memory contents per TAP plus debug register state.
  logic [31:0]  ref_mem0 [int unsigned];
  logic [31:0]  ref_mem1 [int unsigned];
  logic [31:0]  ref_last_addr;
  logic [31:0]  ref_rdata0;
  logic [31:0]  ref_rdata1;
  int unsigned  known_idx [$];

  always #5 wb_clk_i = ~wb_clk_i;

  soc_or1k_wb_jtag_mem dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .tms_pad_i  (tms_pad_i),
    .tck_pad_i  (tck_pad_i),
    .tdi_pad_i  (tdi_pad_i),
    .tdo_pad0_o (tdo_pad0_o),
    .tdo_pad1_o (tdo_pad1_o)
  );

  function automatic int unsigned word_idx(input logic [31:0] addr);
    return (addr % MEM_SIZE) / 4;
  endfunction

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One TCK period: TDO sampled just before the rising edge, 4 clocks high, 6 low.
  task automatic tck_cycle(input logic tms, input logic tdi, output logic o0, output logic o1);
    @(negedge wb_clk_i);
    o0        = tdo_pad0_o;
    o1        = tdo_pad1_o;
    tms_pad_i = tms;
    tdi_pad_i = tdi;
    tck_pad_i = 1'b1;
    repeat (4) @(negedge wb_clk_i);
    tck_pad_i = 1'b0;
    repeat (5) @(negedge wb_clk_i);
  endtask

  task automatic tms_step(input logic tms);
    logic o0, o1;
    tck_cycle(tms, 1'b0, o0, o1);
  endtask

  // From Run-Test/Idle: load IR and return to Run-Test/Idle.
  task automatic shift_ir(input logic [3:0] v);
    logic o0, o1;
    tms_step(1'b1);
    tms_step(1'b1);
    tms_step(1'b0);
    tms_step(1'b0);
    for (int i = 0; i < 4; i++) tck_cycle(i == 3, v[i], o0, o1);
    tms_step(1'b1);
    tms_step(1'b0);
  endtask

  // From Run-Test/Idle: shift n DR bits LSB first, update, return to Run-Test/Idle.
  task automatic shift_dr(input logic [64:0] din, input int n,
                          output logic [64:0] d0, output logic [64:0] d1);
    logic o0, o1;
    d0 = '0;
    d1 = '0;
    tms_step(1'b1);
    tms_step(1'b0);
    tms_step(1'b0);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], o0, o1);
      d0[i] = o0;
      d1[i] = o1;
    end
    tms_step(1'b1);
    tms_step(1'b0);
  endtask

  // One DEBUG access: checks the captured {0, last_addr, rdata} then applies the op to the model.
  task automatic debug_op(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input string tag);
    logic [64:0]  d0, d1;
    int unsigned  idx;
    shift_dr({we, addr, data}, 65, d0, d1);
    check({tag, "_cap0"}, d0, {1'b0, ref_last_addr, ref_rdata0});
    check({tag, "_cap1"}, d1, {1'b0, ref_last_addr, ref_rdata1});
    idx = word_idx(addr);
    if (we) begin
      ref_mem0[idx] = data;
      ref_mem1[idx] = data;
      known_idx.push_back(idx);
    end else begin
      ref_rdata0 = ref_mem0[idx];
      ref_rdata1 = ref_mem1[idx];
    end
    ref_last_addr = addr;
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge wb_clk_i);
    wb_rst_i  = 1'b1;
    tck_pad_i = 1'b0;
    #1;
    check("rst_tdo0", 65'(tdo_pad0_o), 65'd0);
    check("rst_tdo1", 65'(tdo_pad1_o), 65'd0);
    repeat (cycles) @(negedge wb_clk_i);
    wb_rst_i      = 1'b0;
    ref_last_addr = '0;
    ref_rdata0    = '0;
    ref_rdata1    = '0;
    repeat (3) @(negedge wb_clk_i);
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [64:0] d0, d1, din;
    logic [31:0] a, w;

    wb_rst_i  = 1'b1;
    tms_pad_i = 1'b0;
    tck_pad_i = 1'b0;
    tdi_pad_i = 1'b0;

    // Backdoor preload; the model mirrors it.
    dut.wb_bfm_memory0.ram0.mem[0] = 32'h12345678;
    dut.wb_bfm_memory1.ram0.mem[0] = 32'h9ABCDEF0;
    dut.wb_bfm_memory0.ram0.mem[7] = 32'hA5A50007;
    dut.wb_bfm_memory1.ram0.mem[7] = 32'h5A5A0007;
    ref_mem0[0] = 32'h12345678;
    ref_mem1[0] = 32'h9ABCDEF0;
    ref_mem0[7] = 32'hA5A50007;
    ref_mem1[7] = 32'h5A5A0007;
    known_idx.push_back(0);
    known_idx.push_back(7);
    ref_last_addr = '0;
    ref_rdata0    = '0;
    ref_rdata1    = '0;

    // Reset: 100 ns, then wb_rst drops on the 2nd rising edge.
    #100;
    check("wb_rst_held", 65'(dut.wb_rst), 65'd1);
    check("rst_tdo0", 65'(tdo_pad0_o), 65'd0);
    check("rst_tdo1", 65'(tdo_pad1_o), 65'd0);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("wb_rst_edge1", 65'(dut.wb_rst), 65'd1);
    @(posedge wb_clk_i); #1;
    check("wb_rst_edge2", 65'(dut.wb_rst), 65'd0);

    // IDCODE straight out of Test-Logic-Reset.
    tms_step(1'b0);
    din = {$urandom, $urandom, $urandom};
    shift_dr(din, 32, d0, d1);
    check("idcode0", d0, 65'(IDCODE0));
    check("idcode1", d1, 65'(IDCODE1));

    // BYPASS: output is input delayed by one bit, starting with the captured 0.
    shift_ir(4'b1111);
    din = 65'b11010;
    shift_dr(din, 5, d0, d1);
    check("bypass_fixed0", d0, 65'b10100);
    check("bypass_fixed1", d1, 65'b10100);
    din = 65'($urandom_range(0, 16'hFFFF));
    shift_dr(din, 16, d0, d1);
    check("bypass_rand0", d0, {din[63:0], 1'b0} & 65'hFFFF);
    check("bypass_rand1", d1, {din[63:0], 1'b0} & 65'hFFFF);

    // Unknown instruction behaves as BYPASS.
    shift_ir(4'b0110);
    din = 65'($urandom_range(0, 16'hFFFF));
    shift_dr(din, 16, d0, d1);
    check("unk_ir0", d0, {din[63:0], 1'b0} & 65'hFFFF);

    // Explicit IDCODE instruction.
    shift_ir(4'b0010);
    din = {$urandom, $urandom, $urandom};
    shift_dr(din, 32, d0, d1);
    check("ir_idcode0", d0, 65'(IDCODE0));
    check("ir_idcode1", d1, 65'(IDCODE1));

    // DEBUG write, then reads of backdoor data.
    shift_ir(4'b1000);
    debug_op(1'b1, 32'h00000010, 32'hDEADBEEF, "wr10");
    check("bd_mem0_4", 65'(dut.wb_bfm_memory0.ram0.mem[4]), 65'(ref_mem0[4]));
    check("bd_mem1_4", 65'(dut.wb_bfm_memory1.ram0.mem[4]), 65'(ref_mem1[4]));
    debug_op(1'b0, 32'h00000000, $urandom, "rd0");
    debug_op(1'b0, 32'h00000010, $urandom, "rd10");
    debug_op(1'b0, 32'h0000001C, $urandom, "rd1c");

    // Address wrap: MEM_SIZE + 8 lands on word 2.
    w = $urandom;
    debug_op(1'b1, MEM_SIZE + 8, w, "wrwrap");
    check("wrap_mem0_2", 65'(dut.wb_bfm_memory0.ram0.mem[2]), 65'(ref_mem0[2]));
    check("wrap_mem1_2", 65'(dut.wb_bfm_memory1.ram0.mem[2]), 65'(ref_mem1[2]));
    debug_op(1'b0, 32'h00000008, $urandom, "rd8");

    // Randomized writes and aliased reads.
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = MEM_SIZE * $urandom_range(0, 127)
            + known_idx[$urandom_range(0, known_idx.size() - 1)] * 4 + $urandom_range(0, 3);
        debug_op(1'b0, a, $urandom, "rnd_rd");
      end else begin
        debug_op(1'b1, $urandom, $urandom, "rnd_wr");
      end
    end
    debug_op(1'b0, 32'h00000000, $urandom, "rnd_flush");

    // Reset in the middle of a DEBUG write shift: no write may happen.
    tms_step(1'b1);
    tms_step(1'b0);
    tms_step(1'b0);
    din = {1'b1, 32'h0000001C, 32'hFFFF0000};
    for (int i = 0; i < 40; i++) begin
      logic o0, o1;
      tck_cycle(1'b0, din[i], o0, o1);
    end
    apply_reset(4);
    check("abort_mem0_7", 65'(dut.wb_bfm_memory0.ram0.mem[7]), 65'(ref_mem0[7]));
    check("abort_mem1_7", 65'(dut.wb_bfm_memory1.ram0.mem[7]), 65'(ref_mem1[7]));

    // After reset, IR is IDCODE and debug registers are cleared.
    tms_step(1'b0);
    din = {$urandom, $urandom, $urandom};
    shift_dr(din, 32, d0, d1);
    check("post_rst_id0", d0, 65'(IDCODE0));
    check("post_rst_id1", d1, 65'(IDCODE1));
    shift_ir(4'b1000);
    debug_op(1'b0, 32'h0000001C, $urandom, "post_rst_rd");
    debug_op(1'b0, 32'h00000004, $urandom, "post_rst_rd2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/soc_or1k_wb_jtag_mem.md
Name: soc_or1k_wb_jtag_mem

Overview:
- Simulation-oriented dual-memory SoC core driven over JTAG, used as the DUT of the OR1K Wishbone system bench.
- Holds two word-addressed memories (memory 0 and memory 1), each reachable through its own JTAG TAP.
- Both TAPs share TMS/TCK/TDI and have separate TDO pads.
- JTAG pins are oversampled in the single system clock domain. The block also generates the internal system reset `wb_rst`.

Parameters:
- MEM_SIZE, 32'h02000000, bytes per memory; each memory holds MEM_SIZE/4 32-bit words.
- IDCODE0, 32'h149511C3, IDCODE value of TAP 0.
- IDCODE1, 32'h249511C3, IDCODE value of TAP 1.

Ports:
- wb_clk_i  in  1  system clock, the only clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- tms_pad_i  in  1  JTAG TMS, shared by both TAPs.
- tck_pad_i  in  1  JTAG TCK, treated as data and oversampled.
- tdi_pad_i  in  1  JTAG TDI, shared by both TAPs.
- tdo_pad0_o  out  1  TAP 0 TDO.
- tdo_pad1_o  out  1  TAP 1 TDO.

Behaviour:
- One clock: wb_clk_i. Reset is asynchronous and active-high, on wb_rst_i.
- Internal wb_rst:
  - Asserts asynchronously with wb_rst_i.
  - Deasserts on the 2nd wb_clk_i rising edge after wb_rst_i falls.
  - Must be hierarchically visible as dut.wb_rst.
- Memories:
  - Two word arrays, each 32 bits x MEM_SIZE/4, with hierarchical paths wb_bfm_memory0.ram0.mem[] and wb_bfm_memory1.ram0.mem[].
  - Not reset; contents persist across wb_rst. The bench may write them by backdoor at time 0.
  - Word index = addr[log2(MEM_SIZE)-1:2]; upper address bits are ignored (wrap-around).
- Pin sampling:
  - tck, tms and tdi each pass through a 2-flop synchronizer.
  - A TCK rising edge is detected when sync stage 2 = 1 and stage 3 = 0; a falling edge when stage 2 = 0 and stage 3 = 1.
  - tms/tdi are taken from the equally delayed stage.
  - TCK high and low phases must each be at least 3 wb_clk_i periods; shorter phases are undefined.
- TAP state machine (identical, independent instance per memory):
  - Standard IEEE 1149.1 16-state FSM, advanced on each detected TCK rising edge according to TMS.
  - Five TCK rising edges with TMS=1 reach Test-Logic-Reset from any state.
  - Test-Logic-Reset loads IR = IDCODE.
- Instruction register:
  - 4 bits. Capture-IR loads 4'b0101. Shift is LSB first. Update-IR latches the shifted value.
  - Decode: 4'b0010 = IDCODE, 4'b1000 = DEBUG, 4'b1111 = BYPASS; all other codes select BYPASS.
- Data registers:
  - IDCODE: 32-bit register; Capture-DR loads IDCODEn.
  - BYPASS: 1 bit; Capture-DR loads 0.
  - DEBUG: 65 bits, fields {we[64], addr[63:32], data[31:0]}.
    - Capture-DR loads {1'b0, last_addr, rdata}.
    - On Update-DR with we=1: mem[addr] <= data.
    - On Update-DR with we=0: rdata <= mem[addr].
    - In both cases last_addr <= addr. The action completes within 1 wb_clk_i after the Update-DR edge.
- Shift behaviour: all registers shift LSB first. TDI enters at the MSB on each Shift-IR/Shift-DR rising edge.
- TDO timing: each TDO output registers bit 0 of the selected shift register on the detected TCK falling edge while in Shift-IR/Shift-DR; it holds its value otherwise.
- Reset state (wb_rst asserted):
  - Both TAPs in Test-Logic-Reset, IR = IDCODE.
  - tdo_pad0_o = tdo_pad1_o = 0.
  - rdata = 0, last_addr = 0.
  - Reset mid-shift aborts the shift with no memory write.
- Simultaneous accesses: both TAPs see identical TMS/TDI. Each acts only on its own memory, so both update in the same cycle without interaction.

Test Plan:
- Reset: hold wb_rst_i for 100 ns, release -> wb_rst falls 2 clocks later; both TDO = 0; TAPs in Test-Logic-Reset.
- IDCODE read: from reset, go to Shift-DR and shift 32 bits -> tdo_pad0_o yields 32'h149511C3 and tdo_pad1_o yields 32'h249511C3, LSB first.
- Bypass: load IR = 4'b1111, shift pattern 1011 with a leading 0 -> TDO shows the pattern delayed by one bit.
- Debug write: IR = DEBUG, shift {1, 32'h00000010, 32'hDEADBEEF}, Update-DR -> mem0[4] = mem1[4] = 32'hDEADBEEF.
- Debug read of backdoor data: preload mem0[0] = 32'h12345678 and mem1[0] = 32'h9ABCDEF0; shift a read of address 0, then Capture-DR/shift -> low 32 bits on tdo_pad0_o/tdo_pad1_o equal the respective words.
- Wrap: write to address MEM_SIZE + 8 -> word index 2 is updated.
